// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU data port, the host request port and the
// single-port data memory that the arbiter shares between them.
interface dmem_arbiter_if;
    logic [15:0] cpu_addr;
    logic        cpu_oe;
    logic [1:0]  cpu_we;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;

    logic        h_req;
    logic [1:0]  h_we;
    logic [15:0] h_addr;
    logic [15:0] h_wdata;
    logic        h_rdy;
    logic        h_done;
    logic [15:0] h_rdata;
    logic        h_starve;

    logic [15:0] m_addr;
    logic        m_oe;
    logic [1:0]  m_we;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;

    modport slave (
        input  cpu_addr, cpu_oe, cpu_we, cpu_wdata,
        output cpu_rdata,
        input  h_req, h_we, h_addr, h_wdata,
        output h_rdy, h_done, h_rdata, h_starve,
        output m_addr, m_oe, m_we, m_wdata,
        input  m_rdata
    );

    modport master (
        output cpu_addr, cpu_oe, cpu_we, cpu_wdata,
        input  cpu_rdata,
        output h_req, h_we, h_addr, h_wdata,
        input  h_rdy, h_done, h_rdata, h_starve,
        input  m_addr, m_oe, m_we, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU owns the memory whenever it accesses it; a
// single host request is held and slipped into the first CPU-free cycle.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 16
) (
    input logic             clk,
    input logic             rst,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state;
    logic [1:0]  req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [7:0]  wait_cnt;
    logic [15:0] rdata_q;

    logic cpu_busy, host_go, accept;

    assign cpu_busy = bus.cpu_oe | (|bus.cpu_we);
    assign host_go  = (state == PEND) && !cpu_busy;
    assign accept   = (state == IDLE) && bus.h_req;

    // Memory mux: CPU first, held host request only in a free PEND cycle.
    always_comb begin
        bus.m_addr  = '0;
        bus.m_oe    = 1'b0;
        bus.m_we    = 2'b00;
        bus.m_wdata = '0;
        if (cpu_busy) begin
            bus.m_addr  = bus.cpu_addr;
            bus.m_oe    = bus.cpu_oe;
            bus.m_we    = bus.cpu_we;
            bus.m_wdata = bus.cpu_wdata;
        end else if (host_go) begin
            bus.m_addr  = req_addr;
            bus.m_oe    = (req_we == 2'b00);
            bus.m_we    = req_we;
            bus.m_wdata = req_wdata;
        end
    end

    assign bus.cpu_rdata = bus.m_rdata;
    assign bus.h_rdy     = (state == IDLE);
    assign bus.h_done    = (state == RESP);
    assign bus.h_rdata   = rdata_q;
    assign bus.h_starve  = (state == PEND) && (wait_cnt >= LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_we    <= 2'b00;
            req_addr  <= '0;
            req_wdata <= '0;
            wait_cnt  <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    req_we    <= bus.h_we;
                    req_addr  <= bus.h_addr;
                    req_wdata <= bus.h_wdata;
                    wait_cnt  <= '0;
                    state     <= PEND;
                end
                PEND: begin
                    if (host_go) begin
                        if (req_we == 2'b00) rdata_q <= bus.m_rdata;
                        state <= RESP;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 16, is the number of pending cycles after which h_starve asserts; legal range 1..255.
REQ-002 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 Port rst, input, 1, reset: one clock; reset is synchronous and active-high.
REQ-004 Port cpu_addr, input, 16, CPU data address.
REQ-005 Port cpu_oe, input, 1, CPU read enable.
REQ-006 Port cpu_we, input, 2, CPU byte write enables (11 word, 01 upper byte, 10 lower byte).
REQ-007 Port cpu_wdata, input, 16, CPU write data.
REQ-008 Port cpu_rdata, output, 16, CPU read data.
REQ-009 Port h_req, input, 1, host request valid.
REQ-010 Port h_we, input, 2, host byte write enables (00 = read), same lane encoding as cpu_we.
REQ-011 Port h_addr, input, 16, host address.
REQ-012 Port h_wdata, input, 16, host write data.
REQ-013 Port h_rdy, output, 1, arbiter can accept a host request.
REQ-014 Port h_done, output, 1, one-cycle completion pulse.
REQ-015 Port h_rdata, output, 16, host read data, valid while h_done=1.
REQ-016 Port h_starve, output, 1, host request pending >= STARVE_LIMIT cycles.
REQ-017 Ports m_addr (16), m_oe (1), m_we (2), m_wdata (16), outputs, to single-port data memory; m_rdata, input, 16, combinational read data from memory.

Function
REQ-018 CPU has absolute priority and is never stalled; cpu_* forwarded to m_* combinationally in any cycle with cpu_oe=1 or cpu_we!=00.
REQ-019 cpu_rdata = m_rdata combinationally at all times.
REQ-020 FSM states IDLE, PEND, RESP; reset state IDLE.
REQ-021 h_rdy = 1 only in IDLE; request accepted on an edge where h_req=1 and h_rdy=1; h_we/h_addr/h_wdata captured into internal registers at that edge; IDLE -> PEND.
REQ-022 h_req while h_rdy=0 is ignored; no queueing beyond one request.
REQ-023 PEND, free cycle (cpu_oe=0 and cpu_we=00): m_addr=stored addr, m_we=stored we, m_wdata=stored wdata, m_oe=1 iff stored we=00; at edge, h_rdata <= m_rdata if read (else unchanged); PEND -> RESP.
REQ-024 PEND, CPU busy cycle: stay in PEND; memory driven by CPU only.
REQ-025 RESP: h_done=1 for exactly one cycle (reads and writes); RESP -> IDLE unconditionally; h_rdy=0 in RESP (no accept in RESP cycle).
REQ-026 Idle memory (no CPU, no host access): m_oe=0, m_we=00, m_addr=0, m_wdata=0.
REQ-027 Minimum latency: accept at edge T, memory access cycle after T, h_done in the cycle after T+1 edge, i.e. 2 cycles accept-to-done; next accept no earlier than 3 cycles after previous.
REQ-028 Wait counter, 8 bits: cleared on accept, increments each PEND cycle with CPU busy, saturates at 255.
REQ-029 h_starve = 1 while state=PEND and counter >= STARVE_LIMIT; 0 otherwise; diagnostic only, does not override CPU priority.
REQ-030 Host and CPU never drive memory in the same cycle; m_we from host only in PEND free cycle.

Reset
REQ-031 rst=1 at edge: state IDLE, counter 0, h_rdata 0, stored request cleared; any pending/in-flight host request discarded with no h_done.
REQ-032 Outputs during/after reset: h_rdy=1 (after edge), h_done=0, h_starve=0, m_* per REQ-018/026.

Verification
REQ-033 CPU idle, host write h_we=11 addr 0x0010 data 0xBEEF accepted at T -> m_we=11 next cycle, h_done pulse cycle after, memory[0x0010]=0xBEEF.
REQ-034 Then host read addr 0x0010 -> h_done=1 with h_rdata=0xBEEF, exactly 2 cycles after accept.
REQ-035 Host read pending, cpu_oe=1 for 20 consecutive cycles (STARVE_LIMIT=16) -> m_* driven by CPU every cycle, h_starve rises after 16 busy cycles, completes on first free cycle, h_starve clears.
REQ-036 CPU store cpu_we=01 addr 0x0020 in same cycle as host pending write -> CPU store hits memory, host write deferred to next free cycle; no cycle with both.
REQ-037 rst asserted while PEND -> no h_done, h_rdy=1 after reset edge, memory unmodified by host.
REQ-038 h_req held high continuously, CPU idle -> accepts every 3 cycles, h_done one per request.
